// File: rtl/farbborg_loader.sv
// rtl/farbborg_loader.sv - write sequencer for the Farbborg PWM engine byte port
// Turns CPU commands and a byte stream into frame, table, fill and enable write bursts.
module farbborg_loader #(
  parameter int PLANES      = 5,
  parameter int LATCHES     = 12,
  parameter int AUTO_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd,
  input  logic [7:0]  cmd_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [10:0] addr,
  output logic [7:0]  din,
  output logic        we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_TABLE,
    ST_FILL,
    ST_ENABLE
  } state_t;

  localparam logic [3:0]  LATCH_LAST = 4'(LATCHES - 1);
  localparam logic [2:0]  PLANE_LAST = 3'(PLANES - 1);
  localparam logic [10:0] EN_ADDR    = 11'h755;
  localparam logic [7:0]  EN_DATA    = 8'h23;

  state_t      state_q, state_d;
  logic [2:0]  byte_q, byte_d;
  logic [3:0]  latch_q, latch_d;
  logic [2:0]  plane_q, plane_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  fill_q, fill_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        we_q, we_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;

  logic [10:0] frame_addr;
  logic [2:0]  byte_nx;
  logic [3:0]  latch_nx;
  logic [2:0]  plane_nx;
  logic        frame_wrap;

  assign frame_addr = {1'b0, plane_q, latch_q, byte_q};

  // Frame counter advance: byte innermost, then latch, then plane.
  always_comb begin
    byte_nx    = byte_q + 3'd1;
    latch_nx   = latch_q;
    plane_nx   = plane_q;
    frame_wrap = 1'b0;
    if (byte_q == 3'd7) begin
      latch_nx = latch_q + 4'd1;
      if (latch_q == LATCH_LAST) begin
        latch_nx = 4'd0;
        plane_nx = plane_q + 3'd1;
        if (plane_q == PLANE_LAST) begin
          plane_nx   = 3'd0;
          frame_wrap = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    latch_d = latch_q;
    plane_d = plane_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    pend_d  = 1'b0;
    done_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          byte_d  = 3'd0;
          latch_d = 4'd0;
          plane_d = 3'd0;
          idx_d   = 9'd0;
          fill_d  = cmd_data;
          case (cmd)
            2'd0:    state_d = ST_FRAME;
            2'd1:    state_d = ST_TABLE;
            2'd2:    state_d = ST_FILL;
            default: state_d = ST_ENABLE;
          endcase
        end
      end
      ST_FRAME, ST_FILL: begin
        if (state_q == ST_FILL || s_valid) begin
          we_d    = 1'b1;
          addr_d  = frame_addr;
          din_d   = (state_q == ST_FILL) ? fill_q : s_data;
          byte_d  = byte_nx;
          latch_d = latch_nx;
          plane_d = plane_nx;
          if (frame_wrap) begin
            state_d = ST_IDLE;
            pend_d  = 1'b1;
          end
        end
      end
      ST_TABLE: begin
        if (s_valid) begin
          we_d   = 1'b1;
          addr_d = {2'b10, idx_q};
          din_d  = s_data;
          idx_d  = idx_q + 9'd1;
          // Table writes stop the PWM engine, so by default re-enable it afterwards.
          if (idx_q == 9'd511) begin
            state_d = (AUTO_ENABLE != 0) ? ST_ENABLE : ST_IDLE;
            pend_d  = (AUTO_ENABLE == 0);
          end
        end
      end
      ST_ENABLE: begin
        we_d    = 1'b1;
        addr_d  = EN_ADDR;
        din_d   = EN_DATA;
        state_d = ST_IDLE;
        pend_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      byte_q  <= 3'd0;
      latch_q <= 4'd0;
      plane_q <= 3'd0;
      idx_q   <= 9'd0;
      fill_q  <= 8'd0;
      addr_q  <= 11'd0;
      din_q   <= 8'd0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      latch_q <= latch_d;
      plane_q <= plane_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign s_ready   = (state_q == ST_FRAME) || (state_q == ST_TABLE);
  assign addr      = addr_q;
  assign din       = din_q;
  assign we        = we_q;
  assign done      = done_q;

endmodule

// File: tb/tb_farbborg_loader.sv
// tb/tb_farbborg_loader.sv - scoreboard bench for farbborg_loader
// Driver pushes expected writes and done pulses; negedge monitors pop and compare.
module tb_farbborg_loader;
  localparam int LATCHES = 12;
  localparam int PLANES  = 5;
  localparam int FRAME_N = 8 * LATCHES * PLANES;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, s_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] cmd_data = 8'd0, s_data = 8'd0;
  logic cmd_ready, s_ready, we, busy, done;
  logic [10:0] addr;
  logic [7:0] din;

  logic b_cmd_valid = 1'b0, b_s_valid = 1'b0;
  logic [1:0] b_cmd = 2'd0;
  logic [7:0] b_s_data = 8'd0;
  logic b_cmd_ready, b_s_ready, b_we, b_busy, b_done;
  logic [10:0] b_addr;
  logic [7:0] b_din;

  always #5 clk = ~clk;

  farbborg_loader #(.PLANES(PLANES), .LATCHES(LATCHES), .AUTO_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_data(cmd_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .addr(addr), .din(din), .we(we), .busy(busy), .done(done));

  farbborg_loader #(.PLANES(PLANES), .LATCHES(LATCHES), .AUTO_ENABLE(0)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd(b_cmd), .cmd_data(8'h00), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .addr(b_addr), .din(b_din), .we(b_we), .busy(b_busy), .done(b_done));

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  checks = 0, failures = 0;
  int  wr_cnt = 0;
  int  b_wr = 0, b_en = 0, b_dn = 0;
  wr_t mon_e;
  int  mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic logic [10:0] frame_addr_model(int i);
    int plane, latch, byt;
    plane = i / (8 * LATCHES);
    latch = (i / 8) % LATCHES;
    byt   = i % 8;
    return 11'(plane * 128 + latch * 8 + byt);
  endfunction

  function automatic void push_wr(logic [10:0] a, logic [7:0] d, int c);
    wr_t e;
    e.a = a; e.d = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Cycle numbering: the period ending at edge K is cycle K; at a negedge that is cyc+1.
  always @(negedge clk) begin
    if (!reset) begin
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write_addr", int'(addr), -1);
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(addr), int'(mon_e.a));
          chk("wr_data", int'(din), int'(mon_e.d));
          chk("wr_cycle", cyc + 1, mon_e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done_cycle", cyc + 1, -1);
        else begin
          mon_d = done_q.pop_front();
          chk("done_cycle", cyc + 1, mon_d);
        end
      end
      if (b_we) begin
        chk("tblB_addr", int'(b_addr), 'h400 + b_wr);
        chk("tblB_data", int'(b_din), (b_wr ^ 'h5A) & 'hFF);
        b_wr++;
        if (b_addr == 11'h755) b_en++;
      end
      if (b_done) b_dn++;
    end
  end

  task automatic issue_cmd(input logic [1:0] c, input logic [7:0] d, output int n);
    @(negedge clk);
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd = c; cmd_data = d;
    n = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // mode 0: incrementing data, 1: random. toggle: valid every other cycle.
  // cut >= 0: assert reset right after byte index cut is accepted; its write is lost.
  task automatic stream(input int n, input int mode, input bit toggle, input int pct,
                        input bit pulse, input bit is_table, input int cut);
    int cnt = 0, it = 0, k = 0;
    logic [7:0] d;
    logic v;
    while (cnt < n) begin
      v = toggle ? ((it % 2) == 0) : ($urandom_range(99) < pct);
      cmd_valid = pulse && (it >= 150) && (it < 153);
      cmd = 2'd3;
      d = (mode == 0) ? 8'(cnt) : 8'($urandom);
      s_valid = v; s_data = d;
      if (v) begin
        chk("s_ready_busy", int'(s_ready), 1);
        k = cyc + 1;
        if (cnt != cut)
          push_wr(is_table ? 11'('h400 + cnt) : frame_addr_model(cnt), d, k + 1);
        cnt++;
      end
      it++;
      if (cut >= 0 && cnt > cut) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_we_low", int'(we), 0);
        chk("reset_busy_low", int'(busy), 0);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    cmd_valid = 1'b0;
    if (is_table) begin
      push_wr(11'h755, 8'h23, k + 2);
      done_q.push_back(k + 3);
    end else begin
      done_q.push_back(k + 2);
    end
  endtask

  task automatic drain(input string name);
    int budget = 1500;
    while ((exp_q.size() != 0 || done_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({name, "_pending"}, exp_q.size() + done_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_fill(input logic [7:0] v);
    int n;
    issue_cmd(2'd2, v, n);
    for (int i = 0; i < FRAME_N; i++) push_wr(frame_addr_model(i), v, n + 2 + i);
    done_q.push_back(n + 2 + FRAME_N);
    s_valid = 1'b1;
    for (int i = 0; i < FRAME_N; i++) begin
      chk("fill_s_ready", int'(s_ready), 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    drain("fill");
  endtask

  initial begin
    int n, w0;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_s_ready", int'(s_ready), 0);

    w0 = wr_cnt;
    s_valid = 1'b1;
    repeat (10) @(negedge clk);
    s_valid = 1'b0;
    chk("idle_no_writes", wr_cnt - w0, 0);

    issue_cmd(2'd0, 8'h00, n);
    stream(FRAME_N, 0, 1'b0, 100, 1'b0, 1'b0, -1);
    drain("frame_inc");

    issue_cmd(2'd0, 8'h00, n);
    stream(FRAME_N, 1, 1'b1, 0, 1'b1, 1'b0, -1);
    drain("frame_toggle");

    issue_cmd(2'd1, 8'h00, n);
    stream(512, 1, 1'b0, 75, 1'b0, 1'b1, -1);
    drain("table_auto");

    run_fill(8'hA5);
    run_fill(8'($urandom));

    issue_cmd(2'd3, 8'h00, n);
    push_wr(11'h755, 8'h23, n + 2);
    done_q.push_back(n + 3);
    drain("enable");

    issue_cmd(2'd0, 8'h00, n);
    stream(100, 1, 1'b0, 100, 1'b0, 1'b0, 99);
    @(negedge clk);
    reset = 1'b0;
    drain("reset_mid");

    issue_cmd(2'd0, 8'h00, n);
    stream(FRAME_N, 1, 1'b0, 60, 1'b0, 1'b0, -1);
    drain("frame_after_reset");

    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd = 2'd1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 512; i++) begin
      b_s_valid = 1'b1; b_s_data = 8'(i ^ 'h5A);
      @(negedge clk);
    end
    b_s_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("tblB_writes", b_wr, 512);
    chk("tblB_enable_writes", b_en, 0);
    chk("tblB_done", b_dn, 1);
    chk("tblB_busy", int'(b_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
